rf_dump_reader: RTL
===================

Name: rf_dump_reader

Overview:
- Read-side sequencer for the 32x32 register file. On a start pulse it walks a register address range through one RF read port and streams {address, data} pairs out on a valid/ready interface.
- Used for debug and trace dumps of the multicycle CPU's architectural state.
- Asserts hold_o while active so the controller can suppress RegWr, which gives a coherent snapshot.

Parameters:
- FIRST_REG, 0: first register index dumped (0..31).
- LAST_REG, 31: last register index dumped (FIRST_REG..31). FIRST_REG > LAST_REG is illegal and is caught by an elaboration-time check.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- start_i  input  1  begin a dump. Sampled only in IDLE.
- abort_i  input  1  cancel the dump in progress.
- busy_o  output  1  high in READ and SEND.
- hold_o  output  1  write-freeze request to the controller; equal to busy_o.
- done_o  output  1  one-cycle pulse after the last pair is accepted.
- ra_o  output  5  RF read address; drives an RF read-address input.
- rd_i  input  32  RF read data; combinational from ra_o.
- out_valid_o  output  1  output pair valid.
- out_ready_i  input  1  consumer accepts the pair.
- out_addr_o  output  5  register index of the current pair.
- out_data_o  output  32  register contents of the current pair.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, idx=FIRST_REG, ra_o=FIRST_REG. busy_o, hold_o, done_o, out_valid_o = 0. out_addr_o=0, out_data_o=0.
- FSM states: IDLE, READ, SEND, DONE.
- IDLE:
  - start_i=1 -> READ, idx<=FIRST_REG.
  - Otherwise stay in IDLE.
- READ (1 cycle):
  - ra_o=idx.
  - At posedge: out_data_o<=rd_i, out_addr_o<=idx, go to SEND.
  - RF writes land on negedge, so rd_i is settled by posedge. Because hold_o is high, no write lands mid-dump.
- SEND:
  - out_valid_o=1.
  - out_addr_o and out_data_o stay stable until accepted.
  - Accept condition: out_valid_o & out_ready_i at posedge.
    - If idx==LAST_REG -> DONE.
    - Else idx<=idx+1 and go to READ.
  - Without acceptance, stay in SEND indefinitely; no timeout.
- DONE (1 cycle): done_o=1, busy_o=0, then IDLE.
- Latency:
  - Start accepted at cycle 0.
  - First out_valid_o at cycle 2.
  - Each register costs 2 cycles when ready is always high.
  - Full 0..31 dump with ready=1: last acceptance at cycle 64, done_o at cycle 65.
- idx is 5 bits. It never wraps, because the increment is suppressed at LAST_REG. LAST_REG=31 therefore terminates without wrapping to 0.
- Register 0 is dumped like any other and reads 0.
- start_i while busy or in DONE: ignored; no restart and no queueing.
- abort_i (READ or SEND):
  - Next state IDLE.
  - out_valid_o drops next cycle; no done_o.
  - A pair accepted in the same cycle as abort counts as delivered.
  - abort_i in IDLE or DONE: no effect.
- rst has priority over abort_i and start_i. Reset mid-dump returns to IDLE with the reset values above.
- Ordering: pairs appear in strictly ascending address order with no duplicates and no gaps.

Decomposition:
- Shared package (cpu_dbg_pkg):
  - REG_ADDR_W=5, DATA_W=32.
  - State enum constants: IDLE=2'd0, READ=2'd1, SEND=2'd2, DONE=2'd3.
- Single flat module; no sub-module is warranted. The output holding register is folded into the SEND state.

Test Plan:
- Full dump, ready always 1. RF preloaded with regs[i]=i*0x11, regs[28]=0x00001800, regs[29]=0x00002FFE.
  - Pulse start.
  - Expect 32 pairs, addr 0..31, with data matching the preload (addr 0 -> 0x0).
  - done_o at cycle 65; busy_o low afterwards.
- Backpressure: FIRST_REG=28, LAST_REG=29, out_ready_i low for 5 cycles while addr 28 is valid.
  - Expect 0x00001800 held stable for all 5 cycles, then addr 29 / 0x00002FFE.
  - done_o one cycle after the second acceptance.
- Abort mid-dump after 3 acceptances (addr 0..2).
  - Expect out_valid_o low the next cycle, no done_o, return to IDLE.
  - A new start then begins again at addr 0.
- Reset while in SEND at addr 10.
  - Expect all outputs at reset values the next cycle.
  - No further pairs until a new start.
- start_i held high throughout a dump with FIRST_REG=LAST_REG=5.
  - Expect exactly one pair (addr 5), done_o, then a fresh dump starting from IDLE.
- Write-freeze: controller gates RegWr with hold_o; bench attempts to write regs[7]=0xDEADBEEF during the dump.
  - Expect the old value of regs[7] in the dump.
  - Write is not applied while hold_o=1.

Source files
------------

// File: rtl/cpu_dbg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_dbg_pkg
// Purpose  : Shared widths and dump-sequencer state encoding for CPU debug.
// Revision : 1.0
// ============================================================================
package cpu_dbg_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } dump_state_t;

endpackage
`default_nettype wire

// File: rtl/rf_dump_reader.sv
`default_nettype none
// ============================================================================
// Module   : rf_dump_reader
// Purpose  : Walks a register-file address range and streams {addr, data}.
// Revision : 1.0
// ============================================================================
module rf_dump_reader
    import cpu_dbg_pkg::*;
#(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  abort_i,
    output logic                  busy_o,
    output logic                  hold_o,
    output logic                  done_o,
    output logic [REG_ADDR_W-1:0] ra_o,
    input  logic [DATA_W-1:0]     rd_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [REG_ADDR_W-1:0] out_addr_o,
    output logic [DATA_W-1:0]     out_data_o
);

    localparam logic [REG_ADDR_W-1:0] C_FIRST = REG_ADDR_W'(FIRST_REG);
    localparam logic [REG_ADDR_W-1:0] C_LAST  = REG_ADDR_W'(LAST_REG);

    generate
        if (FIRST_REG < 0 || FIRST_REG > LAST_REG || LAST_REG >= NUM_REGS) begin : g_bad_range
            $error("rf_dump_reader: illegal register range FIRST_REG=%0d LAST_REG=%0d",
                   FIRST_REG, LAST_REG);
        end
    endgenerate

    dump_state_t           r_state;
    logic [REG_ADDR_W-1:0] r_idx;

    // The read port simply follows the walking index; it is only consumed in READ.
    assign ra_o   = r_idx;
    assign hold_o = busy_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= C_FIRST;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            out_valid_o <= 1'b0;
            out_addr_o  <= '0;
            out_data_o  <= '0;
        end else begin
            done_o <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_state <= READ;
                        r_idx   <= C_FIRST;
                        busy_o  <= 1'b1;
                    end
                end
                READ: begin
                    if (abort_i) begin
                        r_state <= IDLE;
                        busy_o  <= 1'b0;
                    end else begin
                        out_addr_o  <= r_idx;
                        out_data_o  <= rd_i;
                        out_valid_o <= 1'b1;
                        r_state     <= SEND;
                    end
                end
                SEND: begin
                    // A pair accepted together with abort is already delivered.
                    if (abort_i) begin
                        r_state     <= IDLE;
                        busy_o      <= 1'b0;
                        out_valid_o <= 1'b0;
                    end else if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        if (r_idx == C_LAST) begin
                            r_state <= DONE;
                            busy_o  <= 1'b0;
                            done_o  <= 1'b1;
                        end else begin
                            r_idx   <= r_idx + REG_ADDR_W'(1);
                            r_state <= READ;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
